// File: rtl/ir_sensor_scanner.sv
// Time-multiplexed IR obstacle scanner: bursts a carrier on one emitter at a time,
// compares the receiver echo with and without the emitter, and debounces a per-channel clear flag.
module ir_sensor_scanner #(
    parameter int CARRIER_HALF = 4,
    parameter int BURST_LEN    = 32,
    parameter int QUIET_LEN    = 32,
    parameter int DEBOUNCE     = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scan_en,
    input  logic [3:0] ir_rx_n,
    output logic [3:0] ir_tx,
    output logic [3:0] ir_clear,
    output logic       frame_done,
    output logic       ir_valid
);

    localparam int PHASE_MAX = (BURST_LEN > QUIET_LEN) ? BURST_LEN : QUIET_LEN;
    localparam int PW        = $clog2(PHASE_MAX);
    localparam int CW        = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;

    localparam logic [PW-1:0] BURST_LAST   = PW'(BURST_LEN - 1);
    localparam logic [PW-1:0] QUIET_LAST   = PW'(QUIET_LEN - 1);
    localparam logic [CW-1:0] CARRIER_LAST = CW'(CARRIER_HALF - 1);
    localparam logic [3:0]    DEB_LIMIT    = 4'(DEBOUNCE);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        QUIET = 2'd2
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [PW-1:0]   phase;
    logic [1:0]      ch;
    logic [CW-1:0]   car_cnt;
    logic            carrier;
    logic            echo_on;
    logic [3:0]      rx_meta_n;
    logic [3:0]      rx_sync_n;
    logic [3:0]      echo;
    logic [3:0]      dcnt [4];
    logic            burst_end;
    logic            quiet_end;
    logic            raw_clear;

    // Receivers idle high, so the synchronizer resets to "no carrier".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_n <= 4'hF;
            rx_sync_n <= 4'hF;
        end else begin
            // NOTE: non-blocking assignments make both flops sample the old value, forming a true two-stage chain.
            rx_meta_n <= ir_rx_n;
            rx_sync_n <= rx_meta_n;
        end
    end

    assign echo      = ~rx_sync_n;
    assign burst_end = (state == BURST) && (phase == BURST_LAST);
    assign quiet_end = (state == QUIET) && (phase == QUIET_LAST);
    // An echo that persists with the emitter off is ambient light, not a reflection.
    assign raw_clear = ~(echo_on & ~echo[ch]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (scan_en) next_state = BURST;
            BURST:   if (!scan_en) next_state = IDLE;
                     else if (phase == BURST_LAST) next_state = QUIET;
            QUIET:   if (!scan_en) next_state = IDLE;
                     else if (phase == QUIET_LAST) next_state = BURST;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        // NOTE: default first so every path assigns ir_tx and no latch is inferred.
        ir_tx = 4'b0000;
        if (state == BURST) ir_tx[ch] = carrier;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase   <= '0;
            ch      <= 2'd0;
            car_cnt <= '0;
            carrier <= 1'b0;
            echo_on <= 1'b0;
        end else begin
            if (next_state != state || state == IDLE) phase <= '0;
            else                                      phase <= phase + 1'b1;

            if (next_state == IDLE) ch <= 2'd0;
            else if (quiet_end)     ch <= ch + 2'd1;

            if (next_state == BURST && state != BURST) begin
                carrier <= 1'b1;
                car_cnt <= '0;
            end else if (state == BURST) begin
                if (car_cnt == CARRIER_LAST) begin
                    car_cnt <= '0;
                    carrier <= ~carrier;
                end else begin
                    car_cnt <= car_cnt + 1'b1;
                end
            end

            if (burst_end) echo_on <= echo[ch];
        end
    end

    // A result completed in the last QUIET cycle is applied even if scan_en drops in that cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_clear   <= 4'b0000;
            frame_done <= 1'b0;
            ir_valid   <= 1'b0;
            // NOTE: the small counter array is reset explicitly; every entry is state that must start at zero.
            for (int i = 0; i < 4; i++) dcnt[i] <= 4'd0;
        end else begin
            frame_done <= 1'b0;
            if (quiet_end) begin
                if (raw_clear == ir_clear[ch]) begin
                    dcnt[ch] <= 4'd0;
                end else if (dcnt[ch] + 4'd1 == DEB_LIMIT) begin
                    ir_clear[ch] <= ~ir_clear[ch];
                    dcnt[ch]     <= 4'd0;
                end else begin
                    dcnt[ch] <= dcnt[ch] + 4'd1;
                end
                if (ch == 2'd3) begin
                    frame_done <= 1'b1;
                    ir_valid   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/ir_sensor_scanner.md
# ir_sensor_scanner

Active front end for the obstacle-avoidance sensors. It drives four IR emitters with a modulated carrier, one channel at a time. For each channel it samples the matching active-low demodulating receiver, once with the emitter on and once with it off. It then debounces the result and presents one clean "path clear" level per channel (1 = clear, 0 = obstacle) to the motor-decision logic that consumes IR1..IR4.

## Interface
Parameters:
- CARRIER_HALF, 4: carrier half-period in clk cycles; the carrier toggles every CARRIER_HALF cycles.
- BURST_LEN, 32: emitter-on phase length in clk cycles; must be ≥ 2*CARRIER_HALF and ≥ 4.
- QUIET_LEN, 32: emitter-off (ambient) phase length in clk cycles; must be ≥ 4.
- DEBOUNCE, 2: consecutive disagreeing scans of a channel needed to change its output; range 1..15.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: asynchronous, active-low reset.
- scan_en, input, 1: scanning enable.
- ir_rx_n, input, 4: raw receiver outputs; low = carrier detected; asynchronous to clk.
- ir_tx, output, 4: emitter drives; at most one bit is non-zero at any time.
- ir_clear, output, 4: debounced per-channel result; bit i feeds IRi+1; 1 = clear.
- frame_done, output, 1: one-cycle pulse when all four channels have been updated.
- ir_valid, output, 1: sticky; set at the first frame_done after reset.

## Operation
- ir_rx_n passes through a 2-FF synchronizer per bit. The synchronized echo is echo[i] = ~rx_sync_n[i].
- FSM states: IDLE, BURST, QUIET. A 2-bit channel index ch selects the active channel.
- IDLE: ir_tx = 0, ch = 0, phase counter = 0. Go to BURST when scan_en = 1.
- BURST: lasts BURST_LEN cycles.
  - ir_tx[ch] = carrier and all other bits are 0.
  - The carrier is 1 in the first BURST cycle and toggles every CARRIER_HALF cycles. The carrier counter resets at each BURST entry.
  - echo_on is captured from echo[ch] in the last BURST cycle. The FSM then goes to QUIET.
- QUIET: lasts QUIET_LEN cycles with ir_tx = 0.
  - echo_off is captured from echo[ch] in the last QUIET cycle.
  - raw_clear = ~(echo_on & ~echo_off). A reflection seen under ambient light counts as clear.
  - The FSM then goes to BURST with ch+1, wrapping 3 to 0.
- Debounce, per channel, using a 4-bit counter dcnt[i]:
  - On each sample of channel i: if raw_clear == ir_clear[i], dcnt[i] is set to 0.
  - Otherwise dcnt[i] increments. When the incremented value reaches DEBOUNCE, ir_clear[i] is inverted and dcnt[i] is set to 0.
- frame_done: pulses in the cycle in which the channel-3 result is applied. ir_valid is set in that same cycle.
- scan_en deasserted in any state: the next state is IDLE.
  - The in-progress channel's partial samples are discarded; ir_clear and dcnt are not changed.
  - ir_tx is 0 starting the cycle after scan_en falls.
  - Re-enabling restarts the scan at channel 0.
- If scan_en falls in the last QUIET cycle, that channel's result is still applied. If it was channel 3, frame_done still pulses.

## Timing
- Reset values: ir_tx = 0, ir_clear = 4'b0000 (all obstacle, the safe default), frame_done = 0, ir_valid = 0, state IDLE, ch = 0, all dcnt = 0.
- Input to sample latency: 2 cycles (synchronizer). An echo must be stable for at least 3 cycles before the sample cycle to be seen.
- One channel takes BURST_LEN + QUIET_LEN cycles. One frame takes 4× that: 256 cycles with the defaults.
- The first BURST cycle is the cycle after scan_en is seen high in IDLE.
- ir_clear[i] and frame_done are registered. They change in the cycle after the last QUIET cycle, which is the first BURST cycle of the next channel.
- The earliest first frame_done after enable is cycle 4*(BURST_LEN+QUIET_LEN), counting the first BURST cycle as cycle 0.

## Test plan
- Reset and defaults: assert rst_n = 0 mid-BURST, asynchronously → ir_tx = 0 and ir_clear = 0000 immediately. ir_valid = 0 until the first frame_done, which arrives 256 cycles after scan_en goes high. With ir_rx_n = 1111 held, ir_clear is 1111 after the second frame (DEBOUNCE = 2).
- Carrier and one-hot check: with default parameters, check that ir_tx[0] reads 1,1,1,1,0,0,0,0,… for 32 cycles while ir_tx[3:1] = 0. Check that ir_tx is 0 for the next 32 cycles, then ir_tx[1] starts the same pattern.
- Obstacle detection: drive ir_rx_n[2] = 0 only during channel 2's BURST, with all else 1 → ir_clear[2] falls 0→… stays 0, or falls from 1 to 0 after 2 frames. The other bits are unaffected.
- Ambient rejection: hold ir_rx_n[1] = 0 constantly → ir_clear[1] = 1 (clear).
- Debounce glitch: from ir_clear = 1111, inject a channel-0 echo for one frame only → ir_clear[0] stays 1 and dcnt[0] returns to 0. Two consecutive frames with the echo → ir_clear[0] = 0 at the second channel-0 update.
- Enable abort: drop scan_en in cycle 10 of channel 1's BURST → ir_tx = 0 from cycle 11, no frame_done, ir_clear unchanged. Re-raising scan_en → ir_tx[0] bursts first.
